// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing defaults and the coordinate type used by the
// raster generator and the downstream object comparators.
package vga_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FRONT  = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BACK   = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FRONT  = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BACK   = 33;
    localparam int unsigned VGA_CLK_DIV  = 2;

    // Largest axis period a 10-bit coordinate can count through.
    localparam int unsigned VGA_MAX_TOTAL = 1024;

    typedef logic [9:0] coord_t;

    function automatic int unsigned axis_total(
        input int unsigned active,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back
    );
        return active + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of vga_timing_gen; the frame_start pulse exists only
// when VGA_FRAME_START_EN is defined.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic   vga_clk;
    logic   hsync;
    logic   vsync;
    logic   blank_n;
    logic   active;
    coord_t pixel_x;
    coord_t pixel_y;
`ifdef VGA_FRAME_START_EN
    logic   frame_start;

    modport master (
        output vga_clk, hsync, vsync, blank_n, active, pixel_x, pixel_y, frame_start
    );
    modport slave (
        input  vga_clk, hsync, vsync, blank_n, active, pixel_x, pixel_y, frame_start
    );
`else
    modport master (
        output vga_clk, hsync, vsync, blank_n, active, pixel_x, pixel_y
    );
    modport slave (
        input  vga_clk, hsync, vsync, blank_n, active, pixel_x, pixel_y
    );
`endif

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus combinational decode of
// sync and visible regions for the current count.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned FRONT  = VGA_H_FRONT,
    parameter int unsigned SYNC   = VGA_H_SYNC,
    parameter int unsigned BACK   = VGA_H_BACK
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    output coord_t count,
    output logic   wrap,
    output logic   sync_n,
    output logic   in_active
);

    localparam int unsigned TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);

    if (TOTAL > VGA_MAX_TOTAL) begin : g_bad_total
        $error("vga_axis_counter: axis total %0d exceeds %0d", TOTAL, VGA_MAX_TOTAL);
    end

    // Decode is done one bit wider so a sync window ending exactly at 1024 still works.
    localparam logic [10:0] LAST    = 11'(TOTAL - 1);
    localparam logic [10:0] ACT_END = 11'(ACTIVE);
    localparam logic [10:0] SYNC_LO = 11'(ACTIVE + FRONT);
    localparam logic [10:0] SYNC_HI = 11'(ACTIVE + FRONT + SYNC);

    coord_t      r_count;
    logic [10:0] w_count_ext;

    assign w_count_ext = {1'b0, r_count};
    assign wrap        = en && (w_count_ext == LAST);
    assign sync_n      = !((w_count_ext >= SYNC_LO) && (w_count_ext < SYNC_HI));
    assign in_active   = (w_count_ext < ACT_END);
    assign count       = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (wrap) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster generator: pixel divider, h/v axis counters and
// registered sync/blank/coordinate outputs. Define VGA_FRAME_START_EN to add
// a one-clock frame_start pulse aligned with the (0,0) presentation.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FRONT  = VGA_H_FRONT,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BACK   = VGA_H_BACK,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FRONT  = VGA_V_FRONT,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BACK   = VGA_V_BACK,
    parameter int unsigned CLK_DIV  = VGA_CLK_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master vga
);

    if ((CLK_DIV < 2) || ((CLK_DIV % 2) != 0)) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV %0d must be even and at least 2", CLK_DIV);
    end

    localparam int unsigned      DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_h_sync_n;
    logic             w_v_sync_n;
    logic             w_h_act;
    logic             w_v_act;
    coord_t           w_h_count;
    coord_t           w_v_count;

    logic             r_hsync;
    logic             r_vsync;
    logic             r_active;
    coord_t           r_pixel_x;
    coord_t           r_pixel_y;

    assign w_tick = (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (w_tick),
        .count     (w_h_count),
        .wrap      (w_h_wrap),
        .sync_n    (w_h_sync_n),
        .in_active (w_h_act)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (w_h_wrap),
        .count     (w_v_count),
        .wrap      (w_v_wrap),
        .sync_n    (w_v_sync_n),
        .in_active (w_v_act)
    );

    // Outputs capture the decode of the position the counters hold on this tick,
    // so they trail the counters by exactly one pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_active  <= 1'b0;
            r_pixel_x <= '0;
            r_pixel_y <= '0;
        end else if (w_tick) begin
            r_hsync   <= w_h_sync_n;
            r_vsync   <= w_v_sync_n;
            r_active  <= w_h_act && w_v_act;
            r_pixel_x <= w_h_count;
            r_pixel_y <= w_v_count;
        end
    end

    a_v_wrap_on_h_wrap: assert property (
        @(posedge clk) disable iff (!rst_n) w_v_wrap |-> w_h_wrap
    );

    assign vga.vga_clk = (r_div_cnt >= DIV_HALF);
    assign vga.hsync   = r_hsync;
    assign vga.vsync   = r_vsync;
    assign vga.blank_n = r_active;
    assign vga.active  = r_active;
    assign vga.pixel_x = r_pixel_x;
    assign vga.pixel_y = r_pixel_y;

`ifdef VGA_FRAME_START_EN
    logic r_frame_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_tick && (w_h_count == '0) && (w_v_count == '0);
        end
    end

    assign vga.frame_start = r_frame_start;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a small-raster instance for vectors, wrap,
// mid-frame reset and frame_start, plus a default-parameter instance for line timing.
module tb_vga_timing_gen;
    import vga_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    vga_timing_gen_if s_if ();
    vga_timing_gen_if d_if ();

    vga_timing_gen #(
        .H_ACTIVE (8),
        .H_FRONT  (2),
        .H_SYNC   (2),
        .H_BACK   (2),
        .V_ACTIVE (4),
        .V_FRONT  (1),
        .V_SYNC   (1),
        .V_BACK   (1),
        .CLK_DIV  (2)
    ) u_dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (s_if)
    );

    vga_timing_gen u_dut_d (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (d_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   n;
        int   x;
        int   y;
        logic hs;
        logic vs;
        logic act;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rst(input string p, input logic vc, input logic hs, input logic vs,
                           input logic bn, input logic ac, input coord_t x, input coord_t y);
        chk({p, ".vga_clk"}, 32'(vc), 0);
        chk({p, ".hsync"},   32'(hs), 1);
        chk({p, ".vsync"},   32'(vs), 1);
        chk({p, ".blank_n"}, 32'(bn), 0);
        chk({p, ".active"},  32'(ac), 0);
        chk({p, ".pixel_x"}, 32'(x),  0);
        chk({p, ".pixel_y"}, 32'(y),  0);
    endtask

    task automatic chk_both_rst(input string p);
        chk_rst({p, ".s"}, s_if.vga_clk, s_if.hsync, s_if.vsync, s_if.blank_n,
                s_if.active, s_if.pixel_x, s_if.pixel_y);
        chk_rst({p, ".d"}, d_if.vga_clk, d_if.hsync, d_if.vsync, d_if.blank_n,
                d_if.active, d_if.pixel_x, d_if.pixel_y);
`ifdef VGA_FRAME_START_EN
        chk({p, ".s.frame_start"}, 32'(s_if.frame_start), 0);
        chk({p, ".d.frame_start"}, 32'(d_if.frame_start), 0);
`endif
    endtask

    // Reset, then release on a falling edge so the next rising edge is edge 1.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cur;
        int max_x;
        int max_y;

        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;

        // Small raster: H 8/2/2/2 (14), V 4/1/1/1 (7); pixel n is at (n%14, (n/14)%7).
        vecs[0]  = '{0,  0,  0, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{7,  7,  0, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{8,  8,  0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{10, 10, 0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{11, 11, 0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{12, 12, 0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{13, 13, 0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{14, 0,  1, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{45, 3,  3, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{56, 0,  4, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{70, 0,  5, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{80, 10, 5, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{84, 0,  6, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{97, 13, 6, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{98, 0,  0, 1'b1, 1'b1, 1'b1};
        vecs[15] = '{99, 1,  0, 1'b1, 1'b1, 1'b1};

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_both_rst("reset");
        rst_n = 1'b1;

        @(posedge clk);
        #1;
        chk("edge1.s.active", 32'(s_if.active), 0);
        chk("edge1.d.active", 32'(d_if.active), 0);
        @(posedge clk);
        @(negedge clk);
        cur = 0;

        for (int i = 0; i < 16; i++) begin
            repeat (2 * (vecs[i].n - cur)) @(negedge clk);
            cur = vecs[i].n;
            chk($sformatf("vec%0d.x", i),       32'(s_if.pixel_x), 32'(vecs[i].x));
            chk($sformatf("vec%0d.y", i),       32'(s_if.pixel_y), 32'(vecs[i].y));
            chk($sformatf("vec%0d.hsync", i),   32'(s_if.hsync),   32'(vecs[i].hs));
            chk($sformatf("vec%0d.vsync", i),   32'(s_if.vsync),   32'(vecs[i].vs));
            chk($sformatf("vec%0d.active", i),  32'(s_if.active),  32'(vecs[i].act));
            chk($sformatf("vec%0d.blank_n", i), 32'(s_if.blank_n), 32'(vecs[i].act));
        end

        // Pixel 99 = (1,0): vga_clk low in the first half, high in the second, position held.
        chk("vclk.lo", 32'(s_if.vga_clk), 0);
        @(negedge clk);
        chk("vclk.hi", 32'(s_if.vga_clk), 1);
        chk("hold.x",  32'(s_if.pixel_x), 1);
        @(negedge clk);
        chk("next.x",  32'(s_if.pixel_x), 2);
        cur = 100;

        max_x = 0;
        max_y = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (int'(s_if.pixel_x) > max_x) max_x = int'(s_if.pixel_x);
            if (int'(s_if.pixel_y) > max_y) max_y = int'(s_if.pixel_y);
        end
        cur = 200;
        chk("range.max_x", 32'(max_x), 13);
        chk("range.max_y", 32'(max_y), 6);

        // Mid-frame reset at (3,3) of the fourth frame (pixel 98*3+45).
        repeat (2 * (339 - cur)) @(negedge clk);
        chk("mid.x", 32'(s_if.pixel_x), 3);
        chk("mid.y", 32'(s_if.pixel_y), 3);
        rst_n = 1'b0;
        #1;
        chk_both_rst("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("restart.x",      32'(s_if.pixel_x), 0);
        chk("restart.y",      32'(s_if.pixel_y), 0);
        chk("restart.active", 32'(s_if.active),  1);
        repeat (2) @(negedge clk);
        chk("restart1.x",     32'(s_if.pixel_x), 1);
        chk("restart1.y",     32'(s_if.pixel_y), 0);

`ifdef VGA_FRAME_START_EN
        begin
            int pulses;
            int first_e;
            int last_e;
            int gap_bad;
            int wide;
            logic prev;
            pulses  = 0;
            first_e = -1;
            last_e  = -1;
            gap_bad = 0;
            wide    = 0;
            prev    = 1'b0;
            do_reset();
            for (int e = 1; e <= 400; e++) begin
                @(posedge clk);
                #1;
                if (s_if.frame_start === 1'b1) begin
                    if (prev) wide++;
                    else begin
                        pulses++;
                        if (first_e < 0) first_e = e;
                        if (last_e >= 0 && (e - last_e) != 196) gap_bad++;
                        last_e = e;
                        if (s_if.pixel_x !== 10'd0 || s_if.pixel_y !== 10'd0) gap_bad++;
                    end
                end
                prev = s_if.frame_start;
            end
            chk("fs.pulses",  32'(pulses),  3);
            chk("fs.first",   32'(first_e), 2);
            chk("fs.period",  32'(gap_bad), 0);
            chk("fs.width",   32'(wide),    0);
        end
`endif

        // Default 640x480 instance: line 0 and the start of line 1, sampled after each edge.
        begin
            int act_cnt;
            int hs_cnt;
            int vs_cnt;
            int act_fall;
            int fall_x;
            int hs_fall1;
            int hs_fall_x;
            int hs_fall2;
            int act_rise;
            int rise_x;
            int rise_y;
            int dmax_x;
            logic p_act;
            logic p_hs;
            act_cnt  = 0;
            hs_cnt   = 0;
            vs_cnt   = 0;
            act_fall = -1;
            fall_x   = -1;
            hs_fall1 = -1;
            hs_fall_x = -1;
            hs_fall2 = -1;
            act_rise = -1;
            rise_x   = -1;
            rise_y   = -1;
            dmax_x   = 0;
            p_act    = 1'b0;
            p_hs     = 1'b1;
            do_reset();
            for (int e = 1; e <= 3300; e++) begin
                @(posedge clk);
                #1;
                if (e < 1602 && d_if.active === 1'b1) act_cnt++;
                if (e < 1602 && d_if.hsync === 1'b0) hs_cnt++;
                if (d_if.vsync !== 1'b1) vs_cnt++;
                if (int'(d_if.pixel_x) > dmax_x) dmax_x = int'(d_if.pixel_x);
                if (p_act && !d_if.active && act_fall < 0) begin
                    act_fall = e;
                    fall_x   = int'(d_if.pixel_x);
                end
                if (!p_act && d_if.active && act_fall > 0 && act_rise < 0) begin
                    act_rise = e;
                    rise_x   = int'(d_if.pixel_x);
                    rise_y   = int'(d_if.pixel_y);
                end
                if (p_hs && !d_if.hsync) begin
                    if (hs_fall1 < 0) begin
                        hs_fall1  = e;
                        hs_fall_x = int'(d_if.pixel_x);
                    end else if (hs_fall2 < 0) begin
                        hs_fall2 = e;
                    end
                end
                p_act = d_if.active;
                p_hs  = d_if.hsync;
            end
            chk("line.active_clks", 32'(act_cnt),   1280);
            chk("line.active_fall", 32'(act_fall),  1282);
            chk("line.fall_x",      32'(fall_x),    640);
            chk("line.hsync_fall",  32'(hs_fall1),  1314);
            chk("line.hsync_x",     32'(hs_fall_x), 656);
            chk("line.hsync_clks",  32'(hs_cnt),    192);
            chk("line.period",      32'(hs_fall2 - hs_fall1), 1600);
            chk("line1.rise",       32'(act_rise),  1602);
            chk("line1.x",          32'(rise_x),    0);
            chk("line1.y",          32'(rise_y),    1);
            chk("line.max_x",       32'(dmax_x),    799);
            chk("line.vsync_low",   32'(vs_cnt),    0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
